// File: rtl/aht10_ctrl_pkg.sv
// rtl/aht10_ctrl_pkg.sv - AHT10 controller constants, state encoding and byte-sequence tables
package aht10_ctrl_pkg;

  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_WRITE = 4'b0010;
  localparam logic [3:0] CMD_READ  = 4'b0100;
  localparam logic [3:0] CMD_STOP  = 4'b1000;

  localparam logic [7:0] AHT_ADDR_W    = 8'h70;
  localparam logic [7:0] AHT_ADDR_R    = 8'h71;
  localparam logic [7:0] AHT_CMD_INIT  = 8'hE1;
  localparam logic [7:0] AHT_INIT_ARG  = 8'h08;
  localparam logic [7:0] AHT_CMD_TRIG  = 8'hAC;
  localparam logic [7:0] AHT_TRIG_ARG  = 8'h33;
  localparam logic [7:0] AHT_ARG_ZERO  = 8'h00;

  localparam logic [2:0] IDX_LAST_WR = 3'd3;
  localparam logic [2:0] IDX_LAST_RD = 3'd6;

  typedef enum logic [6:0] {
    ST_PWR_WAIT  = 7'b000_0001,
    ST_INIT      = 7'b000_0010,
    ST_IDLE      = 7'b000_0100,
    ST_TRIG      = 7'b000_1000,
    ST_MEAS_WAIT = 7'b001_0000,
    ST_READ      = 7'b010_0000,
    ST_DONE      = 7'b100_0000
  } state_t;

  typedef struct packed {
    logic [3:0] cmd;
    logic [7:0] data;
  } i2c_ent_t;

  function automatic i2c_ent_t seq_entry(input state_t st, input logic [2:0] idx);
    i2c_ent_t e;
    e = '0;
    case (st)
      ST_INIT: begin
        case (idx)
          3'd0:    e = '{CMD_START | CMD_WRITE, AHT_ADDR_W};
          3'd1:    e = '{CMD_WRITE, AHT_CMD_INIT};
          3'd2:    e = '{CMD_WRITE, AHT_INIT_ARG};
          default: e = '{CMD_WRITE | CMD_STOP, AHT_ARG_ZERO};
        endcase
      end
      ST_TRIG: begin
        case (idx)
          3'd0:    e = '{CMD_START | CMD_WRITE, AHT_ADDR_W};
          3'd1:    e = '{CMD_WRITE, AHT_CMD_TRIG};
          3'd2:    e = '{CMD_WRITE, AHT_TRIG_ARG};
          default: e = '{CMD_WRITE | CMD_STOP, AHT_ARG_ZERO};
        endcase
      end
      ST_READ: begin
        if (idx == 3'd0)
          e = '{CMD_START | CMD_WRITE, AHT_ADDR_R};
        else if (idx == IDX_LAST_RD)
          e = '{CMD_READ | CMD_STOP, AHT_ARG_ZERO};
        else
          e = '{CMD_READ, AHT_ARG_ZERO};
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic [2:0] seq_last(input state_t st);
    return (st == ST_READ) ? IDX_LAST_RD : IDX_LAST_WR;
  endfunction

endpackage

// File: rtl/aht10_ctrl.sv
// rtl/aht10_ctrl.sv - AHT10 humidity/temperature sensor controller driving a byte-level I2C engine
module aht10_ctrl
  import aht10_ctrl_pkg::*;
#(
  parameter int PWR_CYC   = 2_000_000,
  parameter int MEAS_CYC  = 4_000_000,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        meas_req,
  output logic        busy,
  output logic        init_done,
  output logic        data_vld,
  output logic [19:0] hum,
  output logic [19:0] temp,
  output logic        err,
  output logic        i2c_req,
  output logic [3:0]  i2c_cmd,
  output logic [7:0]  i2c_wdata,
  input  logic [7:0]  i2c_rdata,
  input  logic        i2c_done,
  input  logic        i2c_ack
);

  localparam logic [22:0] PWR_END   = 23'(PWR_CYC - 1);
  localparam logic [22:0] MEAS_END  = 23'(MEAS_CYC - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  state_t       r_state, w_state_n;
  logic [22:0]  r_timer;
  logic [2:0]   r_idx;
  logic [7:0]   r_retry;
  logic         r_pend;
  logic         r_nack;
  logic [5:0][7:0] r_rb;
  logic [19:0]  r_hum, r_temp;
  logic         r_data_vld, r_err, r_init_done;

  i2c_ent_t     w_ent;
  logic [2:0]   w_last_idx;
  logic         w_seq, w_req, w_bdone, w_last, w_wr, w_rd;
  logic         w_nack_mid, w_nack_end;
  logic         w_fail, w_retry_inc, w_init_ok;

  always_comb begin
    w_ent      = seq_entry(r_state, r_idx);
    w_last_idx = seq_last(r_state);
  end

  assign w_seq      = (r_state == ST_INIT) || (r_state == ST_TRIG) || (r_state == ST_READ);
  assign w_req      = w_seq && !r_pend;
  assign w_bdone    = r_pend && i2c_done;
  assign w_last     = (r_idx == w_last_idx);
  assign w_wr       = (w_ent.cmd & CMD_WRITE) != 4'd0;
  assign w_rd       = (w_ent.cmd & CMD_READ) != 4'd0;
  // A NACK mid-sequence skips to the STOP entry; the abort is reported once that entry completes.
  assign w_nack_mid = w_bdone && w_wr && !w_last && i2c_ack;
  assign w_nack_end = w_bdone && w_last && (r_nack || (w_wr && i2c_ack));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_PWR_WAIT;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n   = r_state;
    w_fail      = 1'b0;
    w_retry_inc = 1'b0;
    w_init_ok   = 1'b0;
    case (r_state)
      ST_PWR_WAIT:  if (r_timer == PWR_END) w_state_n = ST_INIT;
      ST_INIT, ST_TRIG, ST_READ: begin
        if (w_bdone && w_last) begin
          if (w_nack_end) begin
            w_fail    = 1'b1;
            w_state_n = (r_state == ST_INIT) ? ST_PWR_WAIT : ST_IDLE;
          end else if (r_state == ST_INIT) begin
            w_init_ok = 1'b1;
            w_state_n = ST_IDLE;
          end else if (r_state == ST_TRIG) begin
            w_state_n = ST_MEAS_WAIT;
          end else if (!r_rb[0][7]) begin
            w_state_n = ST_DONE;
          end else if (r_retry + 8'd1 >= RETRY_MAX) begin
            w_fail    = 1'b1;
            w_state_n = ST_IDLE;
          end else begin
            w_retry_inc = 1'b1;
            w_state_n   = ST_MEAS_WAIT;
          end
        end
      end
      ST_IDLE:      if (meas_req) w_state_n = ST_TRIG;
      ST_MEAS_WAIT: if (r_timer == MEAS_END) w_state_n = ST_READ;
      ST_DONE:      w_state_n = ST_IDLE;
      default:      w_state_n = ST_PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer     <= '0;
      r_idx       <= '0;
      r_retry     <= '0;
      r_pend      <= 1'b0;
      r_nack      <= 1'b0;
      r_rb        <= '0;
      r_hum       <= '0;
      r_temp      <= '0;
      r_data_vld  <= 1'b0;
      r_err       <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_data_vld <= 1'b0;
      r_err      <= w_fail;
      if (w_state_n != r_state) begin
        r_timer <= '0;
        r_idx   <= '0;
        r_nack  <= 1'b0;
        r_pend  <= 1'b0;
      end else begin
        if ((r_state == ST_PWR_WAIT) || (r_state == ST_MEAS_WAIT))
          r_timer <= r_timer + 23'd1;
        if (w_req)        r_pend <= 1'b1;
        else if (w_bdone) r_pend <= 1'b0;
        if (w_nack_mid) begin
          r_nack <= 1'b1;
          r_idx  <= w_last_idx;
        end else if (w_bdone) begin
          r_idx  <= r_idx + 3'd1;
        end
      end
      // Read entries sit at indices 1..6 of the READ table and land in b0..b5.
      if (w_bdone && w_rd)
        r_rb[r_idx - 3'd1] <= i2c_rdata;
      if (w_retry_inc)               r_retry <= r_retry + 8'd1;
      else if (w_state_n == ST_IDLE) r_retry <= '0;
      if (w_init_ok)
        r_init_done <= 1'b1;
      if (r_state == ST_DONE) begin
        r_hum      <= {r_rb[1], r_rb[2], r_rb[3][7:4]};
        r_temp     <= {r_rb[3][3:0], r_rb[4], r_rb[5]};
        r_data_vld <= 1'b1;
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign init_done = r_init_done;
  assign data_vld  = r_data_vld;
  assign hum       = r_hum;
  assign temp      = r_temp;
  assign err       = r_err;
  assign i2c_req   = w_req;
  assign i2c_cmd   = w_req ? w_ent.cmd  : 4'd0;
  assign i2c_wdata = w_req ? w_ent.data : 8'd0;

endmodule

// File: tb/tb_aht10_ctrl.sv
// tb/tb_aht10_ctrl.sv - self-checking bench for aht10_ctrl with an I2C byte-engine responder
module tb_aht10_ctrl;

  localparam int PWR  = 20;
  localparam int MEAS = 50;
  localparam int MAXR = 3;
  localparam int LAT  = 10;
  localparam int NV   = 11;
  localparam logic [3:0] C_S = 4'b0001, C_W = 4'b0010, C_R = 4'b0100, C_P = 4'b1000;

  logic        clk = 1'b0, rst_n = 1'b0, meas_req = 1'b0;
  logic        busy, init_done, data_vld, err, i2c_req;
  logic [19:0] hum, temp;
  logic [3:0]  i2c_cmd;
  logic [7:0]  i2c_wdata, i2c_rdata;
  logic        i2c_done, i2c_ack;

  aht10_ctrl #(.PWR_CYC(PWR), .MEAS_CYC(MEAS), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst_n(rst_n), .meas_req(meas_req), .busy(busy), .init_done(init_done),
    .data_vld(data_vld), .hum(hum), .temp(temp), .err(err), .i2c_req(i2c_req),
    .i2c_cmd(i2c_cmd), .i2c_wdata(i2c_wdata), .i2c_rdata(i2c_rdata),
    .i2c_done(i2c_done), .i2c_ack(i2c_ack)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [3:0] cmd;
    logic [7:0] data;
    int         cyc;
  } xfer_t;

  typedef struct {
    logic [47:0] rd;
    int          busy_reads;
    logic        nack_en;
    logic [7:0]  nack_val;
    logic        exp_vld;
    logic        exp_err;
  } vec_t;

  int          n_chk = 0, n_fail = 0, cyc = 0;
  xfer_t       log_q[$], exp_q[$];
  logic [7:0]  rd_q[$];
  logic        nack_en = 1'b0;
  logic [7:0]  nack_val = 8'h00;
  int          vld_cnt = 0, err_cnt = 0, init_rise = -1;
  logic        init_prev = 1'b0;
  logic [19:0] exp_hum = '0, exp_temp = '0;
  vec_t        vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic xfer_t seq_ent(input int kind, input int i);
    xfer_t e;
    e.cyc = 0;
    if (kind == 2) begin
      e.cmd  = (i == 0) ? (C_S | C_W) : (i == 6) ? (C_R | C_P) : C_R;
      e.data = (i == 0) ? 8'h71 : 8'h00;
    end else begin
      e.cmd = (i == 0) ? (C_S | C_W) : (i == 3) ? (C_W | C_P) : C_W;
      case (i)
        0:       e.data = 8'h70;
        1:       e.data = (kind == 0) ? 8'hE1 : 8'hAC;
        2:       e.data = (kind == 0) ? 8'h08 : 8'h33;
        default: e.data = 8'h00;
      endcase
    end
    return e;
  endfunction

  // Appends the bytes a sequence should put on the bus, honouring a NACKed write byte.
  task automatic add_seq(input int kind, output bit hit);
    int n;
    xfer_t e;
    n = (kind == 2) ? 7 : 4;
    hit = 1'b0;
    for (int i = 0; i < n; i++) begin
      e = seq_ent(kind, i);
      exp_q.push_back(e);
      if (nack_en && e.cmd[1] && (e.data == nack_val)) begin
        hit = 1'b1;
        if (i < n - 1) exp_q.push_back(seq_ent(kind, n - 1));
        break;
      end
    end
  endtask

  task automatic compare_log(input string name);
    check({name, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_cmd%0d", name, i), log_q[i].cmd, exp_q[i].cmd);
      if (exp_q[i].cmd[1]) check($sformatf("%s_data%0d", name, i), log_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic run_meas();
    @(negedge clk);
    meas_req = 1'b1;
    @(negedge clk);
    meas_req = 1'b0;
    check("busy_on_req", busy, 1);
    wait_idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic push_good(input logic [47:0] rd);
    for (int j = 0; j < 6; j++) rd_q.push_back(rd[47 - 8*j -: 8]);
  endtask

  function automatic logic [19:0] model_hum(input logic [47:0] rd);
    int b1, b2, b3;
    b1 = int'(rd[39:32]); b2 = int'(rd[31:24]); b3 = int'(rd[23:16]);
    return 20'(b1 * 4096 + b2 * 16 + b3 / 16);
  endfunction

  function automatic logic [19:0] model_temp(input logic [47:0] rd);
    int b3, b4, b5;
    b3 = int'(rd[23:16]); b4 = int'(rd[15:8]); b5 = int'(rd[7:0]);
    return 20'((b3 % 16) * 65536 + b4 * 256 + b5);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = rst_n ? cyc + 1 : 0;
  end

  initial begin : responder
    int cnt;
    logic pend, ack_nx;
    logic [7:0] rd_nx;
    cnt = 0; pend = 1'b0; ack_nx = 1'b0; rd_nx = 8'h00;
    i2c_done = 1'b0; i2c_ack = 1'b0; i2c_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0; pend = 1'b0; i2c_done = 1'b0; i2c_ack = 1'b0;
        rd_q.delete();
      end else begin
        if (i2c_done) begin
          i2c_done = 1'b0; i2c_ack = 1'b0; pend = 1'b0;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            i2c_done = 1'b1; i2c_ack = ack_nx; i2c_rdata = rd_nx;
          end
        end
        if (i2c_req) begin
          check("one_outstanding", {31'd0, pend}, 0);
          log_q.push_back('{i2c_cmd, i2c_wdata, cyc});
          pend = 1'b1;
          cnt = LAT;
          ack_nx = nack_en && i2c_cmd[1] && (i2c_wdata == nack_val);
          if (i2c_cmd[2] && rd_q.size() > 0) rd_nx = rd_q.pop_front();
          else rd_nx = 8'h00;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (data_vld) vld_cnt++;
    if (err) err_cnt++;
    if (rst_n && init_done && !init_prev) init_rise = cyc;
    init_prev = init_done;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit hit;
    int nreads, n;
    logic [47:0] rnd;

    vecs[0] = '{48'h1C6543_25987A, 0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{48'h1C1111_222233, 3, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[2] = '{48'h18ABCD_EF0123, 1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{48'h1C0000_000000, 0, 1'b1, 8'hAC, 1'b0, 1'b1};
    vecs[4] = '{48'h1C0000_000000, 0, 1'b1, 8'h33, 1'b0, 1'b1};
    vecs[5] = '{48'h1C0000_000000, 0, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{48'h1C0000_000000, 0, 1'b1, 8'h71, 1'b0, 1'b1};
    for (int v = 7; v < NV; v++) begin
      rnd = {16'($urandom), $urandom};
      rnd[47] = 1'b0;
      vecs[v].rd = rnd;
      vecs[v].busy_reads = int'($urandom_range(0, 3));
      vecs[v].nack_en = 1'b0;
      vecs[v].nack_val = 8'h00;
      vecs[v].exp_vld = (vecs[v].busy_reads < MAXR);
      vecs[v].exp_err = (vecs[v].busy_reads >= MAXR);
    end

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_init_done", init_done, 0);
    check("rst_data_vld", data_vld, 0);
    check("rst_err", err, 0);
    check("rst_hum", hum, 0);
    check("rst_temp", temp, 0);
    check("rst_i2c_req", i2c_req, 0);
    check("rst_i2c_cmd", i2c_cmd, 0);
    check("rst_i2c_wdata", i2c_wdata, 0);

    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("init_timeout", init_done, 1);
    repeat (2) @(negedge clk);
    if (log_q.size() > 0) check("first_req_cycle", log_q[0].cyc, PWR);
    add_seq(0, hit);
    compare_log("init");
    check("init_done_cycle", init_rise, PWR + 4 * (LAT + 1));
    check("init_busy", busy, 0);

    for (int v = 0; v < NV; v++) begin
      log_q.delete(); exp_q.delete(); rd_q.delete();
      vld_cnt = 0; err_cnt = 0;
      nack_en = vecs[v].nack_en;
      nack_val = vecs[v].nack_val;
      for (int k = 0; k < vecs[v].busy_reads; k++) begin
        rd_q.push_back(8'h98);
        for (int j = 0; j < 5; j++) rd_q.push_back(8'($urandom));
      end
      push_good(vecs[v].rd);
      add_seq(1, hit);
      if (!hit) begin
        nreads = (vecs[v].busy_reads >= MAXR) ? MAXR : vecs[v].busy_reads + 1;
        for (int r = 0; r < nreads && !hit; r++) add_seq(2, hit);
      end
      run_meas();
      if (vecs[v].exp_vld) begin
        exp_hum  = model_hum(vecs[v].rd);
        exp_temp = model_temp(vecs[v].rd);
      end
      check($sformatf("v%0d_vld_count", v), vld_cnt, {31'd0, vecs[v].exp_vld});
      check($sformatf("v%0d_err_count", v), err_cnt, {31'd0, vecs[v].exp_err});
      check($sformatf("v%0d_hum", v), hum, exp_hum);
      check($sformatf("v%0d_temp", v), temp, exp_temp);
      compare_log($sformatf("v%0d", v));
      for (int i = 1; i < log_q.size(); i++)
        if (log_q[i].cmd[1] && log_q[i].data == 8'h71)
          check($sformatf("v%0d_meas_gap", v), log_q[i].cyc - log_q[i-1].cyc, LAT + 1 + MEAS);
      nack_en = 1'b0;
    end

    // meas_req during MEAS_WAIT must not start another transaction
    log_q.delete(); exp_q.delete(); rd_q.delete();
    vld_cnt = 0; err_cnt = 0;
    push_good(48'h1C6543_25987A);
    add_seq(1, hit);
    add_seq(2, hit);
    @(negedge clk);
    meas_req = 1'b1;
    @(negedge clk);
    meas_req = 1'b0;
    n = 0;
    while (log_q.size() < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mw_trig_seen", {31'd0, log_q.size() >= 4}, 1);
    repeat (20) @(negedge clk);
    meas_req = 1'b1;
    @(negedge clk);
    meas_req = 1'b0;
    check("mw_busy", busy, 1);
    wait_idle();
    repeat (100) @(negedge clk);
    compare_log("mw");
    check("mw_vld_count", vld_cnt, 1);
    check("mw_hum", hum, 20'h65432);
    check("mw_temp", temp, 20'h5987A);

    // asynchronous reset in the middle of a READ sequence
    log_q.delete(); rd_q.delete();
    push_good(48'h1C6543_25987A);
    @(negedge clk);
    meas_req = 1'b1;
    @(negedge clk);
    meas_req = 1'b0;
    n = 0;
    while (log_q.size() < 6 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rr_read_seen", {31'd0, log_q.size() >= 6}, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rr_hum", hum, 0);
    check("rr_temp", temp, 0);
    check("rr_busy", busy, 1);
    check("rr_i2c_req", i2c_req, 0);
    check("rr_init_done", init_done, 0);
    check("rr_data_vld", data_vld, 0);

    // power-up re-runs; NACK on E1 during INIT forces another power-up wait
    repeat (3) @(negedge clk);
    log_q.delete(); exp_q.delete();
    err_cnt = 0; init_rise = -1;
    nack_en = 1'b1;
    nack_val = 8'hE1;
    add_seq(0, hit);
    rst_n = 1'b1;
    n = 0;
    while (err_cnt == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    nack_en = 1'b0;
    check("in_err_count", err_cnt, 1);
    check("in_init_done_low", init_done, 0);
    add_seq(0, hit);
    n = 0;
    while (!init_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("in_init_timeout", init_done, 1);
    repeat (2) @(negedge clk);
    compare_log("in");
    if (log_q.size() >= 4) begin
      check("in_first_req_cycle", log_q[0].cyc, PWR);
      check("in_restart_gap", log_q[3].cyc - log_q[2].cyc, LAT + 1 + PWR);
      check("in_init_done_cycle", init_rise, log_q[3].cyc + 4 * (LAT + 1));
    end
    check("in_err_final", err_cnt, 1);
    check("in_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
